// File: rtl/mod_demod_ctrl.sv
// Round-robin front end for a mod_demod loopback: grants one requester, issues its word,
// waits LATENCY cycles for the demodulated word and hands back a checked response.
module mod_demod_ctrl #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REQ    = 4,
  parameter  int LATENCY    = 2,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         dp_data_in,
  input  logic [DATA_WIDTH-1:0]         dp_demod_data,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [IDX_W-1:0]              resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic [7:0]                    err_count,
  output logic                          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_last;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic [3:0]            r_cnt;

  logic [DATA_WIDTH-1:0] w_lane [NUM_REQ];
  logic [IDX_W:0]        w_sum;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_found;
  logic                  w_grant;
  logic                  w_mismatch;
  logic [NUM_REQ-1:0]    w_ready;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_sum[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[IDX_W-1:0];
      end
    end
  end

  assign w_grant    = (r_state == S_IDLE) && w_found && !rst;
  assign w_mismatch = (dp_demod_data != r_word);
  assign busy       = (r_state != S_IDLE);
  assign req_ready  = w_ready;

  always_comb begin
    w_ready = '0;
    if (w_grant) w_ready[w_gnt_idx] = 1'b1;
  end

  // Grant stage: payload and index latched alongside the accept pulse.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_word <= w_lane[w_gnt_idx];
      r_idx  <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= IDX_W'(NUM_REQ - 1);
      r_cnt      <= '0;
      dp_data_in <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last  <= w_gnt_idx;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dp_data_in <= r_word;
          r_cnt      <= 4'(LATENCY);
          r_state    <= S_WAIT;
        end
        // Capture stage: the error flag is judged once, against the word that was issued.
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            resp_data  <= dp_demod_data;
            resp_id    <= r_idx;
            resp_err   <= w_mismatch;
            resp_valid <= 1'b1;
            if (w_mismatch) err_count <= sat_inc8(err_count);
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_demod_ctrl.sv
// Bench for mod_demod_ctrl: transaction-level timing model checked every cycle, directed
// scenarios with literal expectations, randomized traffic, and LATENCY=1/15 delay builds.
module tb_mod_demod_ctrl;

  localparam int LAT = 2;
  localparam int NR  = 4;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic [DW-1:0] dp_data_in;
  logic [DW-1:0] dp_demod_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [1:0]    resp_id;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [7:0]    err_count;
  logic          busy;

  logic          force_zero;
  logic [DW-1:0] mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign dp_demod_data = force_zero ? '0 : (dp_data_in ^ mask);

  mod_demod_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_data_in(dp_data_in), .dp_demod_data(dp_demod_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .err_count(err_count), .busy(busy)
  );

  // Two extra builds used only to measure grant-to-response delay with ideal loopback.
  logic [NR-1:0]    ax_req_valid [2];
  logic [NR-1:0]    ax_req_ready [2];
  logic [DW-1:0]    ax_dp        [2];
  logic             ax_rv        [2];
  logic [1:0]       ax_id        [2];
  logic [DW-1:0]    ax_rd        [2];
  logic             ax_err       [2];
  logic [7:0]       ax_ec        [2];
  logic             ax_busy      [2];
  logic [NR*DW-1:0] ax_data = 64'h0000_0000_0000_C3C3;
  logic             ax_resp_ready = 1'b1;

  mod_demod_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(ax_req_valid[0]), .req_data(ax_data),
    .req_ready(ax_req_ready[0]), .dp_data_in(ax_dp[0]), .dp_demod_data(ax_dp[0]),
    .resp_valid(ax_rv[0]), .resp_ready(ax_resp_ready), .resp_id(ax_id[0]),
    .resp_data(ax_rd[0]), .resp_err(ax_err[0]), .err_count(ax_ec[0]), .busy(ax_busy[0])
  );

  mod_demod_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .req_valid(ax_req_valid[1]), .req_data(ax_data),
    .req_ready(ax_req_ready[1]), .dp_data_in(ax_dp[1]), .dp_demod_data(ax_dp[1]),
    .resp_valid(ax_rv[1]), .resp_ready(ax_resp_ready), .resp_id(ax_id[1]),
    .resp_data(ax_rd[1]), .resp_err(ax_err[1]), .err_count(ax_ec[1]), .busy(ax_busy[1])
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // Reference model: a transaction is described only by its grant cycle; every output
  // follows from the elapsed cycles since then.
  int            cyc    = 0;
  bit            m_idle = 1'b1;
  int            m_last = NR - 1;
  int            t_g    = 0;
  int            m_id   = 0;
  logic [DW-1:0] m_word = '0;
  logic [DW-1:0] m_dp   = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_rerr = 1'b0;
  int            m_ec   = 0;
  int            n_resp = 0;
  int            gq[$];

  always @(negedge clk) begin : cmp
    int g;
    int age;
    logic [NR-1:0] er;
    cyc++;
    if (rst) begin
      m_idle = 1'b1;
      m_last = NR - 1;
      m_dp   = '0;
      m_ec   = 0;
      n_resp = 0;
      check("reset_outputs",
            {15'd0, req_ready, dp_data_in, resp_valid, resp_id, resp_data, resp_err, err_count, busy},
            64'd0);
    end else begin
      check("err_count", err_count, m_ec);
      if (m_idle) begin
        g  = rr_pick(req_valid, m_last);
        er = (g >= 0) ? NR'(1 << g) : '0;
        check("req_ready_idle", req_ready, er);
        check("busy_idle", busy, 0);
        check("resp_valid_idle", resp_valid, 0);
        check("dp_hold_idle", dp_data_in, m_dp);
        if (g >= 0) begin
          m_idle = 1'b0;
          t_g    = cyc;
          m_last = g;
          m_id   = g;
          m_word = req_data[g*DW +: DW];
          gq.push_back(g);
        end
      end else begin
        age = cyc - t_g;
        if (age >= 2) m_dp = m_word;
        check("dp_data_in", dp_data_in, m_dp);
        check("req_ready_busy", req_ready, 0);
        check("busy", busy, 1);
        check("resp_valid", resp_valid, (age >= LAT + 2) ? 1 : 0);
        if (age == LAT + 1) begin
          m_rdata = force_zero ? '0 : (m_word ^ mask);
          m_rerr  = (m_rdata != m_word);
          if (m_rerr && m_ec < 255) m_ec++;
        end
        if (age >= LAT + 2) begin
          check("resp_id", resp_id, m_id);
          check("resp_data", resp_data, m_rdata);
          check("resp_err", resp_err, m_rerr);
          if (resp_ready) begin
            m_idle = 1'b1;
            n_resp++;
          end
        end
      end
    end
  end

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check(nm, 1, 0);
  endtask

  task automatic wait_resp(input string nm);
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) check(nm, 0, 1);
  endtask

  task automatic wait_grant(input string nm);
    int n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) check(nm, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    int gs [2];
    int lt [2];
    logic [DW-1:0] ad [2];

    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0;
    force_zero = 1'b0; mask = '0;
    ax_req_valid[0] = '0; ax_req_valid[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_dp_data_in", dp_data_in, 0);
    tick();
    rst = 1'b0;

    // Single request from requester 2 with ideal loopback.
    tick();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 16'hA5A5;
    @(negedge clk);
    check("t1_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_ready_pulse", req_ready, 0);
    @(negedge clk);
    check("t1_dp_data_in", dp_data_in, 16'hA5A5);
    lat = 2;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", lat, LAT + 2);
    check("t1_resp_id", resp_id, 2);
    check("t1_resp_data", resp_data, 16'hA5A5);
    check("t1_resp_err", resp_err, 0);
    tick();
    resp_ready = 1'b1;
    wait_idle("t1_idle_timeout");

    // All four requesting continuously: fair rotation from requester 0.
    do_reset();
    gq.delete();
    req_valid = 4'hF;
    req_data = {$urandom, $urandom};
    n = 0;
    while (gq.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_grant_%0d", i), (i < gq.size()) ? gq[i] : -1, exp_g[i]);
    end
    tick();
    req_valid = '0;
    wait_idle("t2_idle_timeout");

    // Forced mismatch: zero comes back while all-ones is issued; counter saturates.
    do_reset();
    force_zero = 1'b1;
    req_data[DW-1:0] = 16'hFFFF;
    req_valid = 4'b0001;
    wait_resp("t3_resp_timeout");
    check("t3_resp_err", resp_err, 1);
    check("t3_resp_data", resp_data, 0);
    check("t3_err_count_1", err_count, 1);
    n = 0;
    while (n_resp < 300 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t3_300_done", (n_resp >= 300) ? 1 : 0, 1);
    check("t3_err_count_sat", err_count, 255);
    tick();
    req_valid = '0;
    wait_idle("t3_idle_timeout");
    tick();
    force_zero = 1'b0;

    // Back-pressure: response must hold while the others wait.
    resp_ready = 1'b0;
    req_data[DW-1:0] = 16'h1234;
    req_valid = 4'b0001;
    wait_grant("t4_grant_timeout");
    tick();
    req_valid = 4'hF;
    wait_resp("t4_resp_timeout");
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", resp_valid, 1);
      check("t4_hold_id", resp_id, 0);
      check("t4_hold_data", resp_data, 16'h1234);
      check("t4_hold_err", resp_err, 0);
      check("t4_no_grant", req_ready, 0);
      if (i < 4) @(negedge clk);
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("t4_next_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_idle("t4_idle_timeout");

    // Reset pulsed while waiting for the demodulated word.
    tick();
    req_data[DW-1:0] = 16'h5A5A;
    req_valid = 4'b0001;
    wait_grant("t5_grant_timeout");
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    #1;
    check("t5_rst_req_ready", req_ready, 0);
    check("t5_rst_dp", dp_data_in, 0);
    check("t5_rst_resp_valid", resp_valid, 0);
    check("t5_rst_resp_id", resp_id, 0);
    check("t5_rst_resp_data", resp_data, 0);
    check("t5_rst_resp_err", resp_err, 0);
    check("t5_rst_err_count", err_count, 0);
    check("t5_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    req_valid = 4'b1010;
    @(negedge clk);
    check("t5_first_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_idle("t5_idle_timeout");

    // Randomized traffic, back-pressure and corruption against the model.
    for (int i = 0; i < 2500; i++) begin
      tick();
      req_valid  = NR'($urandom_range(0, 15));
      req_data   = {$urandom, $urandom};
      resp_ready = ($urandom_range(0, 3) != 0);
      mask       = ($urandom_range(0, 5) == 0) ? DW'($urandom) : '0;
      force_zero = ($urandom_range(0, 15) == 0);
    end
    tick();
    req_valid = '0;
    resp_ready = 1'b1;
    mask = '0;
    force_zero = 1'b0;
    wait_idle("t6_idle_timeout");

    // LATENCY=1 and LATENCY=15 builds: grant-to-response delay.
    gs[0] = -1; gs[1] = -1; lt[0] = -1; lt[1] = -1; ad[0] = '0; ad[1] = '0;
    tick();
    ax_req_valid[0] = 4'b0001;
    ax_req_valid[1] = 4'b0001;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (gs[k] < 0 && ax_req_ready[k] != '0) gs[k] = c;
        else if (gs[k] >= 0 && lt[k] < 0 && ax_rv[k]) begin
          lt[k] = c - gs[k];
          ad[k] = ax_rd[k];
        end
      end
    end
    check("lat1_delay", lt[0], 3);
    check("lat15_delay", lt[1], 17);
    check("lat1_data", ad[0], 16'hC3C3);
    check("lat15_data", ad[1], 16'hC3C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
